digit_serial_adder: RTL

Multi-cycle, parameterised N-bit adder/subtractor that processes operands W bits per clock over K = N/W cycles, with carry held in a flop between digits. It trades latency for area: one W-bit adder replaces a full N-bit carry chain. Used in datapaths where wide add/sub results are not needed every cycle. A start/busy/done handshake launches operations and signals results.

---
 rtl/digit_serial_adder_pkg.sv | 26 ++
 rtl/digit_add.sv | 16 +
 rtl/digit_serial_adder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial adder/subtractor.
package digit_serial_adder_pkg;

  // Controller states: idle, digit processing, one-cycle result presentation.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of digits (clock cycles of work) per operation.
  function automatic int calc_k(input int n, input int w);
    return n / w;
  endfunction

  // Width of the digit counter; always at least one bit so K = 1 still works.
  function automatic int calc_cnt_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // Legal geometry: 1 <= W <= N and N an exact multiple of W.
  function automatic bit cfg_ok(input int n, input int w);
    return (w >= 1) && (w <= n) && ((n % w) == 0);
  endfunction

endpackage

// File: rtl/digit_add.sv
// W-bit combinational adder slice: {cout_o, s_o} = a_i + b_i + cin_i.
module digit_add
  import digit_serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial N-bit adder/subtractor: one W-bit digit per clock over K = N/W
// cycles, carry held in a flop between digits, start/busy/done handshake.
// Optional feature: define DIGIT_SERIAL_ADDER_OVF_EN to add the signed
// overflow output ovf.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  output logic         ovf,
`endif
  output logic         cout
);

  localparam int K  = calc_k(N, W);
  localparam int CW = calc_cnt_w(K);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(K - 1);

  // Reject geometries where the operand does not split into whole digits.
  generate
    if (!cfg_ok(N, W)) begin : g_cfg_err
      $error("digit_serial_adder: N must be a multiple of W and 1 <= W <= N");
    end
  endgenerate

  state_e         state_q;
  logic [N-1:0]   a_sh_q;
  logic [N-1:0]   b_sh_q;
  logic [N-1:0]   psum_q;
  logic [N-1:0]   psum_d;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   sum_q;
  logic           cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic           ovf_q;
  logic           ovf_d;
`endif

  logic [W-1:0]   dig_s;
  logic           dig_c;

  // The single shared W-bit adder works on the low digit of each shifter.
  digit_add #(.W(W)) u_digit_add (
    .a_i    (a_sh_q[W-1:0]),
    .b_i    (b_sh_q[W-1:0]),
    .cin_i  (carry_q),
    .s_o    (dig_s),
    .cout_o (dig_c)
  );

  // New digit enters the top of the partial sum; with K = 1 it is the whole sum.
  generate
    if (W == N) begin : g_single_digit
      assign psum_d = dig_s;
    end else begin : g_multi_digit
      assign psum_d = {dig_s, psum_q[N-1:W]};
    end
  endgenerate

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  // Carry into the MSB recovered from the MSB sum bit, then XORed with cout.
  assign ovf_d = a_sh_q[W-1] ^ b_sh_q[W-1] ^ dig_s[W-1] ^ dig_c;
`endif

  // Controller and datapath: accept in IDLE, one digit per BUSY edge, pulse in DONE.
  // NOTE: every register here uses <= so all flops update from the same
  // pre-edge values; blocking assignments would make ordering matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand shifters and partial sum are reset too; they are few flops
      // and it keeps the whole block at a known state after an abort.
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + ~cin, so invert b and cin once here.
            a_sh_q  <= a;
            b_sh_q  <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          a_sh_q  <= a_sh_q >> W;
          b_sh_q  <= b_sh_q >> W;
          carry_q <= dig_c;
          psum_q  <= psum_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_DIGIT) begin
            // Results are published only on the edge that raises done.
            sum_q   <= psum_d;
            cout_q  <= dig_c;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
